// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - AHB-request to APB master bridge with slave decode, wait-state timeout and error response
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 3,
  parameter int SLV_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  valid,
  input  logic                  Hwrite,
  input  logic [ADDR_W-1:0]     Haddr,
  input  logic [DATA_W/8-1:0]   Hstrb,
  input  logic [DATA_W-1:0]     Hwdata,
  output logic                  Hreadyout,
  output logic [DATA_W-1:0]     Hrdata,
  output logic                  Hresp,
  output logic [ADDR_W-1:0]     Paddr,
  output logic [DATA_W-1:0]     Pwdata,
  output logic                  Pwrite,
  output logic                  Penable,
  output logic [NSLV-1:0]       Pselx,
  output logic [DATA_W/8-1:0]   Pstrb,
  input  logic [DATA_W-1:0]     Prdata,
  input  logic                  Pready,
  input  logic                  Pslverr
);

  // Slave index field is at least one bit wide even for a single slave.
  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  // One extra bit so NSLV itself is representable for the range compare.
  localparam logic [IDX_W:0] NSLV_L = (IDX_W+1)'(NSLV);
  // Counter wide enough for TIMEOUT-1; never zero width.
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx_in;
  logic [IDX_W-1:0] sel_idx;
  logic             dec_ok;
  logic             accept;
  logic             access_done;
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  assign idx_in = Haddr[SLV_LSB +: IDX_W];
  assign dec_ok = ({1'b0, idx_in} < NSLV_L);
  assign accept = (state == IDLE) && valid;

  // Pready wins over an expiring timeout in the same cycle.
  assign access_done = (state == ACCESS) && Pready;
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !Pready && (wait_cnt == TO_LAST);

  // State register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and APB/AHB handshake outputs; all outputs decode from state so reset clears them at once.
  always_comb begin
    state_nxt = state;
    Hreadyout = 1'b0;
    Penable   = 1'b0;
    Pselx     = '0;
    case (state)
      IDLE: begin
        Hreadyout = 1'b1;
        if (valid) begin
          if (!dec_ok) begin
            state_nxt = ERR;
          end else if (Hwrite) begin
            state_nxt = WWAIT;
          end else begin
            state_nxt = SETUP;
          end
        end
      end
      WWAIT: begin
        state_nxt = SETUP;
      end
      SETUP: begin
        for (int i = 0; i < NSLV; i++) begin
          Pselx[i] = (sel_idx == IDX_W'(i));
        end
        state_nxt = ACCESS;
      end
      ACCESS: begin
        for (int i = 0; i < NSLV; i++) begin
          Pselx[i] = (sel_idx == IDX_W'(i));
        end
        Penable = 1'b1;
        if (access_done || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request; only decoded requests touch the APB address-side registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Paddr   <= '0;
      Pwrite  <= 1'b0;
      Pstrb   <= '0;
      sel_idx <= '0;
    end else if (accept && dec_ok) begin
      Paddr   <= Haddr;
      Pwrite  <= Hwrite;
      Pstrb   <= Hwrite ? Hstrb : '0;
      sel_idx <= idx_in;
    end
  end

  // Write data arrives in the AHB data phase, i.e. the WWAIT cycle.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Pwdata <= '0;
    end else if (state == WWAIT) begin
      Pwdata <= Hwdata;
    end
  end

  // Wait counter: cleared in SETUP, counts ACCESS cycles where the slave is not ready.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !Pready && (TIMEOUT != 0)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Response registers hold until the next completion, timeout or decode error.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Hresp  <= 1'b0;
      Hrdata <= '0;
    end else if (access_done) begin
      Hresp <= Pslverr;
      if (!Pwrite) begin
        Hrdata <= Prdata;
      end
    end else if (timeout_hit) begin
      Hresp <= 1'b1;
      if (!Pwrite) begin
        Hrdata <= '0;
      end
    end else if (state == ERR) begin
      Hresp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - randomized bench for apb_master_ctrl with a transaction-level reference model
module tb_apb_master_ctrl;

  localparam int TO = 4;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        valid;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [3:0]  Hstrb;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic        Hresp;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [3:0]  Pstrb;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  always #5 Hclk = ~Hclk;

  apb_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NSLV(3), .SLV_LSB(28), .TIMEOUT(TO)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
    .Haddr(Haddr), .Hstrb(Hstrb), .Hwdata(Hwdata),
    .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable),
    .Pselx(Pselx), .Pstrb(Pstrb),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  // One entry per clock cycle after acceptance: what to drive and what to see.
  typedef struct {
    logic        rdy;
    logic [2:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        hresp;
    logic [31:0] hrdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } rec_t;

  rec_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        no_cmp   = 1'b0;
  logic        mdl_hresp;
  logic [31:0] mdl_hrdata;
  int          lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Build the cycle schedule of one request from the bridge's rules, then drive it.
  task automatic run_tx(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input int w, input logic [31:0] prd,
                        input logic serr, output int l);
    rec_t recs[$];
    rec_t r;
    int   idx, n, off, j;
    bit   derr, tmo;
    idx  = int'(addr[29:28]);
    derr = (idx >= 3);
    tmo  = (w >= TO);
    n    = tmo ? TO : w + 1;
    off  = wr ? 1 : 0;
    l    = derr ? 2 : 2 + off + n;
    for (int k = 1; k <= l; k++) begin
      r.rdy     = 1'b0;
      r.sel     = 3'b000;
      r.en      = 1'b0;
      r.wr      = wr;
      r.addr    = addr;
      r.strb    = wr ? strb : 4'h0;
      r.wdata   = wdata;
      r.hresp   = mdl_hresp;
      r.hrdata  = mdl_hrdata;
      r.pready  = 1'($urandom_range(0, 1));
      r.prdata  = $urandom;
      r.pslverr = 1'($urandom_range(0, 1));
      if (k == l) begin
        r.rdy = 1'b1;
        if (derr) begin
          mdl_hresp = 1'b1;
        end else if (tmo) begin
          mdl_hresp = 1'b1;
          if (!wr) mdl_hrdata = 32'h0;
        end else begin
          mdl_hresp = serr;
          if (!wr) mdl_hrdata = prd;
        end
        r.hresp  = mdl_hresp;
        r.hrdata = mdl_hrdata;
      end else if (!derr && k >= 1 + off) begin
        r.sel = 3'(1 << idx);
        j = k - 1 - off;
        if (j >= 1) begin
          r.en     = 1'b1;
          r.pready = (j <= w) ? 1'b0 : 1'b1;
          if (!tmo && j == n) begin
            r.prdata  = prd;
            r.pslverr = serr;
          end
        end
      end
      recs.push_back(r);
    end
    valid   = 1'b1;
    Hwrite  = wr;
    Haddr   = addr;
    Hstrb   = strb;
    Hwdata  = $urandom;
    Pready  = 1'($urandom_range(0, 1));
    Prdata  = $urandom;
    Pslverr = 1'($urandom_range(0, 1));
    foreach (recs[i]) exp_q.push_back(recs[i]);
    for (int k = 1; k <= l; k++) begin
      @(negedge Hclk);
      r       = recs[k-1];
      valid   = (k < l) ? 1'($urandom_range(0, 1)) : 1'b0;
      Hwrite  = 1'($urandom);
      Haddr   = $urandom;
      Hstrb   = 4'($urandom);
      Hwdata  = (wr && k == 1) ? wdata : $urandom;
      Pready  = r.pready;
      Prdata  = r.prdata;
      Pslverr = r.pslverr;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      valid   = 1'b0;
      Haddr   = $urandom;
      Pready  = 1'($urandom_range(0, 1));
      Prdata  = $urandom;
      Pslverr = 1'($urandom_range(0, 1));
      @(negedge Hclk);
    end
  endtask

  // Compare process: checks every cycle just after the rising edge.
  initial begin
    rec_t        r;
    logic        cmp_hresp;
    logic [31:0] cmp_hrdata;
    cmp_hresp  = 1'b0;
    cmp_hrdata = 32'h0;
    forever begin
      @(posedge Hclk);
      #1;
      if (!Hresetn) begin
        cmp_hresp  = 1'b0;
        cmp_hrdata = 32'h0;
      end else if (!no_cmp) begin
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("hreadyout", 64'(Hreadyout), 64'(r.rdy));
          chk("pselx", 64'(Pselx), 64'(r.sel));
          chk("penable", 64'(Penable), 64'(r.en));
          if (r.sel != 3'b000) begin
            chk("paddr", 64'(Paddr), 64'(r.addr));
            chk("pwrite", 64'(Pwrite), 64'(r.wr));
            chk("pstrb", 64'(Pstrb), 64'(r.strb));
            if (r.wr) chk("pwdata", 64'(Pwdata), 64'(r.wdata));
          end
          chk("hresp", 64'(Hresp), 64'(r.hresp));
          chk("hrdata", 64'(Hrdata), 64'(r.hrdata));
          cmp_hresp  = r.hresp;
          cmp_hrdata = r.hrdata;
        end else begin
          chk("idle_hreadyout", 64'(Hreadyout), 64'd1);
          chk("idle_pselx", 64'(Pselx), 64'd0);
          chk("idle_penable", 64'(Penable), 64'd0);
          chk("idle_hresp", 64'(Hresp), 64'(cmp_hresp));
          chk("idle_hrdata", 64'(Hrdata), 64'(cmp_hrdata));
        end
      end
    end
  end

  // Stimulus: directed cases with literal expectations, reset abort, then random traffic.
  initial begin
    Hresetn    = 1'b0;
    valid      = 1'b0;
    Hwrite     = 1'b0;
    Haddr      = 32'h0;
    Hstrb      = 4'h0;
    Hwdata     = 32'h0;
    Prdata     = 32'h0;
    Pready     = 1'b0;
    Pslverr    = 1'b0;
    mdl_hresp  = 1'b0;
    mdl_hrdata = 32'h0;
    repeat (2) @(negedge Hclk);
    chk("rst_hreadyout", 64'(Hreadyout), 64'd1);
    chk("rst_pselx", 64'(Pselx), 64'd0);
    chk("rst_penable", 64'(Penable), 64'd0);
    chk("rst_paddr", 64'(Paddr), 64'd0);
    chk("rst_pstrb", 64'(Pstrb), 64'd0);
    chk("rst_hresp", 64'(Hresp), 64'd0);
    chk("rst_hrdata", 64'(Hrdata), 64'd0);
    Hresetn = 1'b1;

    run_tx(1'b0, 32'h1000_0040, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1'b0, lat);
    chk("rd0_latency", 64'(lat), 64'd3);
    chk("rd0_hreadyout", 64'(Hreadyout), 64'd1);
    chk("rd0_hrdata", 64'(Hrdata), 64'hCAFE_F00D);
    chk("rd0_hresp", 64'(Hresp), 64'd0);

    run_tx(1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678, 2, $urandom, 1'b0, lat);
    chk("wr2_latency", 64'(lat), 64'd6);
    chk("wr2_hresp", 64'(Hresp), 64'd0);

    run_tx(1'b0, 32'h3000_0000, 4'hF, 32'h0, 0, $urandom, 1'b0, lat);
    chk("dec_latency", 64'(lat), 64'd2);
    chk("dec_hresp", 64'(Hresp), 64'd1);

    run_tx(1'b0, 32'h2000_0000, 4'hF, 32'h0, 20, $urandom, 1'b0, lat);
    chk("tmo_latency", 64'(lat), 64'd6);
    chk("tmo_hresp", 64'(Hresp), 64'd1);
    chk("tmo_hrdata", 64'(Hrdata), 64'd0);

    run_tx(1'b1, 32'h0000_0100, 4'hF, $urandom, 1, $urandom, 1'b1, lat);
    chk("slverr_hresp", 64'(Hresp), 64'd1);
    run_tx(1'b0, 32'h1000_0000, 4'hF, 32'h0, 0, 32'h5555_AAAA, 1'b0, lat);
    chk("b2b_hresp", 64'(Hresp), 64'd0);
    chk("b2b_hrdata", 64'(Hrdata), 64'h5555_AAAA);

    run_tx(1'b0, 32'h2000_0004, 4'hF, 32'h0, TO - 1, 32'hA5A5_0001, 1'b0, lat);
    chk("edge_latency", 64'(lat), 64'd6);
    chk("edge_hresp", 64'(Hresp), 64'd0);
    chk("edge_hrdata", 64'(Hrdata), 64'hA5A5_0001);

    no_cmp = 1'b1;
    valid  = 1'b1;
    Hwrite = 1'b0;
    Haddr  = 32'h0000_0080;
    Hstrb  = 4'hF;
    Pready = 1'b0;
    @(negedge Hclk);
    valid = 1'b0;
    @(negedge Hclk);
    chk("abort_penable_before", 64'(Penable), 64'd1);
    #2 Hresetn = 1'b0;
    #1;
    chk("abort_pselx", 64'(Pselx), 64'd0);
    chk("abort_penable", 64'(Penable), 64'd0);
    chk("abort_hreadyout", 64'(Hreadyout), 64'd1);
    chk("abort_hresp", 64'(Hresp), 64'd0);
    chk("abort_hrdata", 64'(Hrdata), 64'd0);
    chk("abort_paddr", 64'(Paddr), 64'd0);
    @(negedge Hclk);
    Hresetn    = 1'b1;
    mdl_hresp  = 1'b0;
    mdl_hrdata = 32'h0;
    no_cmp     = 1'b0;
    run_tx(1'b0, 32'h1000_0008, 4'hF, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, lat);
    chk("post_rst_hrdata", 64'(Hrdata), 64'h0BAD_CAFE);

    repeat (300) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      run_tx(1'($urandom), $urandom, 4'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2),
             $urandom, 1'($urandom_range(0, 3) == 0), lat);
    end
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width; multiple of 8.
- NSLV, default 3: number of APB slaves.
- SLV_LSB, default 28: lowest address bit of the slave index field.
- TIMEOUT, default 16: maximum ACCESS cycles waiting for Pready; 0 disables the timeout.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports are listed as name, direction, width, meaning.
REQ-003 Hclk  in  1  clock; all state changes on its rising edge.
REQ-004 Hresetn  in  1  asynchronous active-low reset.
REQ-005 valid  in  1  AHB request present (address phase).
REQ-006 Hwrite  in  1  request is a write.
REQ-007 Haddr  in  ADDR_W  request address.
REQ-008 Hstrb  in  DATA_W/8  write byte strobes, sampled with the address.
REQ-009 Hwdata  in  DATA_W  write data, valid in the cycle after acceptance (AHB data phase).
REQ-010 Hreadyout  out  1  high = ready to accept a request; also marks the response cycle.
REQ-011 Hrdata  out  DATA_W  read data.
REQ-012 Hresp  out  1  error response.
REQ-013 Paddr  out  ADDR_W; Pwdata  out  DATA_W; Pwrite  out  1; Penable  out  1.
REQ-014 Pselx  out  NSLV  one-hot slave select.
REQ-015 Pstrb  out  DATA_W/8  byte strobes.
REQ-016 Prdata  in  DATA_W; Pready  in  1; Pslverr  in  1.

Function
REQ-017 FSM states SHALL be IDLE, WWAIT, SETUP, ACCESS and ERR; Hreadyout SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur on a rising edge where state is IDLE and valid=1; Haddr, Hwrite and Hstrb are registered on that edge.
REQ-019 Slave index SHALL be Haddr[SLV_LSB +: clog2(NSLV)], with clog2 floored at 1. An index >= NSLV SHALL go IDLE->ERR with no APB activity.
REQ-020 A decoded write SHALL go IDLE->WWAIT. Hwdata SHALL be registered on the WWAIT->SETUP edge.
REQ-021 A decoded read SHALL go IDLE->SETUP.
REQ-022 SETUP SHALL drive the target Pselx bit with Penable=0, and SHALL always go to ACCESS after one cycle.
REQ-023 ACCESS SHALL keep the SETUP outputs with Penable=1. It SHALL stay in ACCESS while Pready=0, and go to IDLE on Pready=1.
REQ-024 From SETUP to the end of ACCESS, Paddr, Pwrite, Pwdata, Pstrb and Pselx SHALL remain stable.
REQ-025 In IDLE, WWAIT and ERR, Pselx SHALL be 0 and Penable SHALL be 0.
REQ-026 Pstrb SHALL equal the registered Hstrb for writes, and 0 for reads.
REQ-027 On ACCESS completion, Hresp SHALL load Pslverr. For reads only, Hrdata SHALL load Prdata. Both SHALL hold until the next completion.
REQ-028 Pslverr and Prdata SHALL be sampled only when Penable=1 and Pready=1.
REQ-029 With TIMEOUT>0, a wait counter SHALL clear on SETUP and increment each ACCESS cycle with Pready=0.
REQ-030 When the wait counter reaches TIMEOUT, the block SHALL go ACCESS->IDLE with Hresp=1. Hrdata SHALL be set to 0 for reads.
REQ-031 ERR SHALL last one cycle, then go to IDLE with Hresp=1.
REQ-032 Latency SHALL be:
- read: acceptance to Hreadyout=1 is 3 cycles plus Pready wait cycles;
- write: 4 cycles plus Pready wait cycles;
- decode error: 2 cycles.
REQ-033 Back-to-back requests SHALL be accepted only in the IDLE response cycle. valid while Hreadyout=0 SHALL be ignored.
REQ-034 Pready=1 in the same cycle as a timeout expiry SHALL complete normally, with Hresp=Pslverr.

Reset
REQ-035 Hresetn=0 SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- set Hreadyout=1;
- set Hrdata, Hresp, Paddr, Pwdata, Pwrite, Penable, Pselx and Pstrb to 0;
- clear the wait counter.
REQ-036 Reset during SETUP or ACCESS SHALL drop Pselx and Penable asynchronously. The aborted transfer SHALL produce no response.
REQ-037 After reset is released, the first rising edge SHALL be able to accept a request.

Verification
REQ-038 Read, zero-wait: Haddr=0x1000_0040, Pready=1, Prdata=0xCAFE_F00D -> Pselx=3'b010 for 2 cycles; Hreadyout=1 and Hrdata=0xCAFE_F00D 3 cycles after acceptance; Hresp=0.
REQ-039 Write with 2 wait states: Haddr=0x0000_0010, Hstrb=4'b0011, Hwdata=0x1234_5678 -> Pstrb=4'b0011, Pwdata=0x1234_5678 stable through ACCESS; Hreadyout=1 6 cycles after acceptance.
REQ-040 Decode error: Haddr=0x3000_0000 with NSLV=3 -> Pselx never asserted; Hresp=1 2 cycles after acceptance.
REQ-041 Timeout: TIMEOUT=4 and Pready held 0 -> ACCESS is exited after 4 wait cycles; Hresp=1; Hrdata=0.
REQ-042 Slave error plus back-to-back: a write with Pslverr=1 -> Hresp=1; a read accepted in the IDLE response cycle -> Hresp returns to 0 on its completion.
REQ-043 Reset mid-ACCESS: Hresetn=0 mid-cycle -> Pselx=0, Penable=0 and Hreadyout=1 before the next clock edge.
